// File: rtl/pipe_pkg.sv
// Shared types and default geometry for the Henad pipeline sequencer.
package pipe_pkg;

   localparam int unsigned PIPE_ADDR_W   = 24;
   localparam int unsigned PIPE_STAGES   = 8;
   localparam int unsigned PIPE_ID_STAGE = 2;
   localparam int unsigned PIPE_BR_STAGE = 3;
   localparam int unsigned PIPE_RESET_PC = 0;
   localparam int unsigned PIPE_CNT_W    = 32;

   typedef enum logic [1:0] {
      SEQ_RUN        = 2'd0,
      SEQ_HALT_DRAIN = 2'd1,
      SEQ_HALTED     = 2'd2
   } seq_state_e;

endpackage

// File: rtl/pipe_seq_valid.sv
// Per-stage valid chain: shift, global freeze, decode-hold bubble and
// clearing of the stages younger than the branch-resolve stage.
module pipe_seq_valid
   import pipe_pkg::*;
#(
   parameter int unsigned STAGES   = PIPE_STAGES,
   parameter int unsigned ID_STAGE = PIPE_ID_STAGE,
   parameter int unsigned BR_STAGE = PIPE_BR_STAGE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              kill,
   input  logic              bubble,
   input  logic              v0_in,
   output logic [STAGES-1:0] v
);

   localparam logic [STAGES-1:0] ONES        = '1;
   localparam logic [STAGES-1:0] HOLD_MASK   = ~(ONES << (ID_STAGE + 1));
   localparam logic [STAGES-1:0] BUBBLE_MASK = ~(ONES << (ID_STAGE + 2)) & (ONES << (ID_STAGE + 1));
   // Slots 1..BR_STAGE would receive the discarded younger instructions.
   localparam logic [STAGES-1:0] KILL_MASK   = ~(ONES << (BR_STAGE + 1)) & (ONES << 1);

   logic [STAGES-1:0] v_q, v_d, shifted;

   assign shifted = {v_q[STAGES-2:0], v0_in};

   always_comb begin
      v_d = v_q;
      if (!freeze) begin
         if (kill) begin
            v_d = shifted & ~KILL_MASK;
         end else if (bubble) begin
            v_d = (v_q & HOLD_MASK) | (shifted & ~HOLD_MASK & ~BUBBLE_MASK);
         end else begin
            v_d = shifted;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) v_q <= '0;
      else      v_q <= v_d;
   end

   assign v = v_q;

endmodule

// File: rtl/pipe_seq.sv
// Pipeline sequencer: PC, redirect/flush, halt drain and restart.
// Optional performance counters are built with PIPE_SEQ_PERF_EN defined.
module pipe_seq
   import pipe_pkg::*;
#(
   parameter int unsigned ADDR_W   = PIPE_ADDR_W,
   parameter int unsigned STAGES   = PIPE_STAGES,
   parameter int unsigned ID_STAGE = PIPE_ID_STAGE,
   parameter int unsigned BR_STAGE = PIPE_BR_STAGE,
   parameter int unsigned RESET_PC = PIPE_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_stall,
   input  logic              hazard_stall,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              halt_req,
   input  logic              resume,
   input  logic [ADDR_W-1:0] resume_pc,
   output logic [ADDR_W-1:0] pc,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] flush,
   output logic              halted
`ifdef PIPE_SEQ_PERF_EN
   ,
   output logic [PIPE_CNT_W-1:0] stall_cnt,
   output logic [PIPE_CNT_W-1:0] flush_cnt
`endif
);

   localparam logic [STAGES-1:0] ONES       = '1;
   localparam logic [STAGES-1:0] YOUNG_MASK = ~(ONES << BR_STAGE);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [STAGES-1:0] flush_q, flush_d;
   logic              halted_q, halted_d;
   logic [STAGES-1:0] v;
   logic              kill, bubble, v0_in;
   logic              br_ok, halt_ok;

   // Branch and HLT only count when the resolve stage holds a live instruction.
   assign br_ok   = br_valid & v[BR_STAGE];
   assign halt_ok = halt_req & v[BR_STAGE];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = '0;
      kill    = 1'b0;
      bubble  = 1'b0;
      v0_in   = 1'b0;
      if (!ext_stall) begin
         case (state_q)
            SEQ_RUN: begin
               v0_in = 1'b1;
               if (halt_ok) begin
                  kill    = 1'b1;
                  v0_in   = 1'b0;
                  flush_d = v & YOUNG_MASK;
                  state_d = SEQ_HALT_DRAIN;
               end else if (br_ok) begin
                  kill    = 1'b1;
                  flush_d = v & YOUNG_MASK;
                  pc_d    = br_target;
               end else if (hazard_stall) begin
                  bubble = 1'b1;
               end else if (v[0]) begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end
            SEQ_HALT_DRAIN: begin
               if (v[STAGES-2:0] == '0) state_d = SEQ_HALTED;
            end
            SEQ_HALTED: begin
               if (resume) begin
                  pc_d    = resume_pc;
                  v0_in   = 1'b1;
                  state_d = SEQ_RUN;
               end
            end
            default: state_d = SEQ_RUN;
         endcase
      end
      halted_d = (state_d == SEQ_HALTED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= SEQ_RUN;
         pc_q     <= ADDR_W'(RESET_PC);
         flush_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         flush_q  <= flush_d;
         halted_q <= halted_d;
      end
   end

   pipe_seq_valid #(
      .STAGES  (STAGES),
      .ID_STAGE(ID_STAGE),
      .BR_STAGE(BR_STAGE)
   ) u_valid (
      .clk   (clk),
      .rst   (rst),
      .freeze(ext_stall),
      .kill  (kill),
      .bubble(bubble),
      .v0_in (v0_in),
      .v     (v)
   );

   assign pc       = pc_q;
   assign stage_en = v;
   assign flush    = flush_q;
   assign halted   = halted_q;

`ifdef PIPE_SEQ_PERF_EN
   logic [PIPE_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PIPE_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters, frozen while halted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != SEQ_HALTED) begin
         if ((ext_stall || bubble) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PIPE_CNT_W'(1);
         if (kill && (flush_cnt_q != '1))                  flush_cnt_d = flush_cnt_q + PIPE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
